// File: rtl/tcp_tx_arbiter.sv
// tcp_tx_arbiter: round-robin segment arbiter muxing two AXI-stream requesters onto one TCP TX stream
module tcp_tx_arbiter #(
  parameter int TCP_DATA_LENGTH = 1456,
  parameter int IDLE_TIMEOUT = 64,
  parameter logic [3:0] TCP_ESTABLISHED = 4'd4
) (
  input  logic        s_aclk,
  input  logic        s_areset,
  input  logic [3:0]  tcp_state_in,
  input  logic        s0_tvalid,
  output logic        s0_tready,
  input  logic [63:0] s0_tdata,
  input  logic [7:0]  s0_tkeep,
  input  logic        s1_tvalid,
  output logic        s1_tready,
  input  logic [63:0] s1_tdata,
  input  logic [7:0]  s1_tkeep,
  output logic        tx_user_tvalid,
  input  logic        tx_user_tready,
  output logic [63:0] tx_user_tdata,
  output logic [7:0]  tx_user_tkeep,
  output logic [1:0]  grant,
  output logic [15:0] seg_cnt0,
  output logic [15:0] seg_cnt1,
  output logic [7:0]  abort_cnt
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state;
  logic last;
  logic armed;
  logic [10:0] byte_cnt;
  logic [7:0] idle_cnt;
  logic sel, xfer, seg_end, timeout, start, pick1;
  logic [3:0] pop;
  logic [11:0] sum;
  // zero-latency data path from the granted requester; armed delays the first grant after reset
  always_comb begin
    sel = state == GNT1;
    tx_user_tvalid = state == GNT0 ? s0_tvalid : sel ? s1_tvalid : 1'b0;
    tx_user_tdata = sel ? s1_tdata : s0_tdata;
    tx_user_tkeep = sel ? s1_tkeep : s0_tkeep;
    s0_tready = state == GNT0 && tx_user_tready;
    s1_tready = sel && tx_user_tready;
    xfer = tx_user_tvalid && tx_user_tready;
    pop = 4'($countones(tx_user_tkeep));
    sum = {1'b0, byte_cnt} + {8'd0, pop};
    seg_end = xfer && (sum >= 12'(TCP_DATA_LENGTH) || tx_user_tkeep != 8'hFF);
    timeout = !xfer && idle_cnt == 8'(IDLE_TIMEOUT);
    pick1 = s1_tvalid && (!s0_tvalid || !last);
    start = state == IDLE && armed && tcp_state_in == TCP_ESTABLISHED && (s0_tvalid || s1_tvalid);
  end
  // grant FSM with segment length, idle timeout and statistics counters
  always_ff @(posedge s_aclk) begin
    if (s_areset) begin
      state <= IDLE;
      grant <= 2'b00;
      last <= 1'b1;
      armed <= 1'b0;
      byte_cnt <= '0;
      idle_cnt <= '0;
      seg_cnt0 <= '0;
      seg_cnt1 <= '0;
      abort_cnt <= '0;
    end else begin
      armed <= 1'b1;
      if (start) begin
        state <= pick1 ? GNT1 : GNT0;
        grant <= pick1 ? 2'b10 : 2'b01;
      end else if (state != IDLE) begin
        if (seg_end || timeout) begin
          state <= IDLE;
          grant <= 2'b00;
          byte_cnt <= '0;
          idle_cnt <= '0;
          last <= sel;
        end
        if (seg_end) begin
          seg_cnt0 <= seg_cnt0 + 16'(!sel);
          seg_cnt1 <= seg_cnt1 + 16'(sel);
        end else if (xfer) begin
          byte_cnt <= sum[10:0];
          idle_cnt <= '0;
        end else if (timeout) abort_cnt <= abort_cnt + 8'(abort_cnt != 8'hFF);
        else if (!tx_user_tvalid) idle_cnt <= idle_cnt + 8'd1;
      end
    end
  end
endmodule
